// File: rtl/pic_irq_core.sv
// ---------------------------------------------------------------------------
// pic_irq_core
//
// Purpose:
//   Clocked, parametrised interrupt controller core in the style of the 8259.
//   Holds the request (IRR), in-service (ISR) and mask (IMR) registers, a
//   fully nested priority resolver with rotation, and a two-strobe INTA
//   acknowledge FSM that returns a vector.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   irq_in                raw request lines (already synchronous to clock)
//   cfg_write, cfg_*      init strobe plus trigger mode / AEOI / auto-rotate /
//                         vector base, latched on cfg_write
//   mask_write, mask_data IMR load
//   eoi_valid, eoi_cmd,   EOI / rotate / set-priority commands
//   eoi_level
//   inta_strobe           one pulse per CPU INTA edge
//   int_out               interrupt request to the CPU
//   vector_valid,         one-cycle vector pulse and its value
//   vector_out
//   irr_out, isr_out,     register status
//   imr_out
// ---------------------------------------------------------------------------
module pic_irq_core #(
  parameter int  NUM_IRQ   = 8,
  parameter int  VEC_WIDTH = 8,
  localparam int IDX_W     = $clog2(NUM_IRQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_IRQ-1:0]   irq_in,
  input  logic                 cfg_write,
  input  logic                 cfg_level,
  input  logic                 cfg_aeoi,
  input  logic                 cfg_auto_rotate,
  input  logic [VEC_WIDTH-1:0] cfg_vector_base,
  input  logic                 mask_write,
  input  logic [NUM_IRQ-1:0]   mask_data,
  input  logic                 eoi_valid,
  input  logic [1:0]           eoi_cmd,
  input  logic [IDX_W-1:0]     eoi_level,
  input  logic                 inta_strobe,
  output logic                 int_out,
  output logic                 vector_valid,
  output logic [VEC_WIDTH-1:0] vector_out,
  output logic [NUM_IRQ-1:0]   irr_out,
  output logic [NUM_IRQ-1:0]   isr_out,
  output logic [NUM_IRQ-1:0]   imr_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } state_e;

  state_e               r_state, w_stateNext;

  logic [NUM_IRQ-1:0]   r_irr, r_isr, r_imr, r_irqPrev;
  logic [IDX_W-1:0]     r_rotateBase, r_ackIdx;
  logic                 r_spurious;
  logic                 r_level, r_aeoi, r_autoRotate;
  logic [VEC_WIDTH-1:0] r_vectorBase;
  logic                 r_intOut, r_vectorValid;
  logic [VEC_WIDTH-1:0] r_vectorOut;

  logic [NUM_IRQ-1:0]   w_pending;
  logic                 w_winValid, w_isrValid;
  logic [IDX_W-1:0]     w_winIdx, w_isrIdx;
  int                   w_ch;
  logic [IDX_W-1:0]     w_chIdx;

  logic [NUM_IRQ-1:0]   w_irrNext, w_isrNext, w_imrNext;
  logic [IDX_W-1:0]     w_rotateNext, w_ackIdxNext;
  logic                 w_spuriousNext, w_intNext, w_vvNext;
  logic [VEC_WIDTH-1:0] w_voutNext;

  assign w_pending = r_irr & ~r_imr;

  // Priority resolver. Channels are scanned from highest priority
  // (rotate_base+1) downwards. The first ISR bit met is the in-service level;
  // a pending request only wins if it is met before any ISR bit, which gives
  // the fully nested behaviour. The ISR scan continues past a winner so that
  // non-specific EOI always sees the highest in-service channel.
  always_comb begin : resolver
    w_winValid = 1'b0;
    w_winIdx   = '0;
    w_isrValid = 1'b0;
    w_isrIdx   = '0;
    w_ch       = 0;
    w_chIdx    = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      w_ch    = (int'(r_rotateBase) + 1 + k) % NUM_IRQ;
      w_chIdx = IDX_W'(w_ch);
      if (r_isr[w_chIdx] && !w_isrValid) begin
        w_isrValid = 1'b1;
        w_isrIdx   = w_chIdx;
      end else if (w_pending[w_chIdx] && !w_isrValid && !w_winValid) begin
        w_winValid = 1'b1;
        w_winIdx   = w_chIdx;
      end
    end
  end

  // Next-state logic for the acknowledge FSM and all controller registers.
  // EOI commands are applied first and the ACK1 grant last, so when both touch
  // the same ISR bit in one cycle the grant (set) wins.
  always_comb begin : nextState
    w_stateNext    = r_state;
    w_irrNext      = r_level ? irq_in : (r_irr | (irq_in & ~r_irqPrev));
    w_isrNext      = r_isr;
    w_imrNext      = mask_write ? mask_data : r_imr;
    w_rotateNext   = r_rotateBase;
    w_ackIdxNext   = r_ackIdx;
    w_spuriousNext = r_spurious;
    w_intNext      = 1'b0;
    w_vvNext       = 1'b0;
    w_voutNext     = r_vectorOut;

    if (eoi_valid) begin
      case (eoi_cmd)
        2'b00: begin
          if (w_isrValid) w_isrNext[w_isrIdx] = 1'b0;
        end
        2'b01: begin
          if (int'(eoi_level) < NUM_IRQ) w_isrNext[eoi_level] = 1'b0;
        end
        2'b10: begin
          if (w_isrValid) begin
            w_isrNext[w_isrIdx] = 1'b0;
            w_rotateNext        = w_isrIdx;
          end
        end
        default: begin
          if (int'(eoi_level) < NUM_IRQ) w_rotateNext = eoi_level;
        end
      endcase
    end

    case (r_state)
      IDLE: begin
        w_intNext = w_winValid;
        if (inta_strobe) begin
          w_stateNext    = ACK1;
          w_intNext      = 1'b0;
          w_spuriousNext = !w_winValid;
          // With no winner the ack is spurious: report the lowest default
          // channel and leave IRR/ISR alone.
          if (w_winValid) begin
            w_ackIdxNext          = w_winIdx;
            w_isrNext[w_winIdx]   = 1'b1;
            w_irrNext[w_winIdx]   = 1'b0;
          end else begin
            w_ackIdxNext = IDX_W'(NUM_IRQ - 1);
          end
        end
      end
      ACK1: begin
        if (inta_strobe) begin
          w_voutNext  = r_vectorBase + VEC_WIDTH'(r_ackIdx);
          w_vvNext    = 1'b1;
          w_stateNext = ACK2;
          if (r_aeoi && !r_spurious) w_isrNext[r_ackIdx] = 1'b0;
          if (r_aeoi && r_autoRotate) w_rotateNext = r_ackIdx;
        end
      end
      ACK2: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State register. cfg_write re-initialises exactly like reset (aborting any
  // acknowledge in progress) and additionally latches the new configuration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_irr         <= '0;
      r_isr         <= '0;
      r_imr         <= '1;
      r_irqPrev     <= '0;
      r_rotateBase  <= IDX_W'(NUM_IRQ - 1);
      r_ackIdx      <= '0;
      r_spurious    <= 1'b0;
      r_intOut      <= 1'b0;
      r_vectorValid <= 1'b0;
      r_vectorOut   <= '0;
      r_level       <= 1'b0;
      r_aeoi        <= 1'b0;
      r_autoRotate  <= 1'b0;
      r_vectorBase  <= '0;
    end else if (cfg_write) begin
      r_state       <= IDLE;
      r_irr         <= '0;
      r_isr         <= '0;
      r_imr         <= '1;
      r_irqPrev     <= '0;
      r_rotateBase  <= IDX_W'(NUM_IRQ - 1);
      r_ackIdx      <= '0;
      r_spurious    <= 1'b0;
      r_intOut      <= 1'b0;
      r_vectorValid <= 1'b0;
      r_vectorOut   <= '0;
      r_level       <= cfg_level;
      r_aeoi        <= cfg_aeoi;
      r_autoRotate  <= cfg_auto_rotate;
      r_vectorBase  <= cfg_vector_base;
    end else begin
      r_state       <= w_stateNext;
      r_irr         <= w_irrNext;
      r_isr         <= w_isrNext;
      r_imr         <= w_imrNext;
      r_irqPrev     <= irq_in;
      r_rotateBase  <= w_rotateNext;
      r_ackIdx      <= w_ackIdxNext;
      r_spurious    <= w_spuriousNext;
      r_intOut      <= w_intNext;
      r_vectorValid <= w_vvNext;
      r_vectorOut   <= w_voutNext;
    end
  end

  assign int_out      = r_intOut;
  assign vector_valid = r_vectorValid;
  assign vector_out   = r_vectorOut;
  assign irr_out      = r_irr;
  assign isr_out      = r_isr;
  assign imr_out      = r_imr;

endmodule

// File: tb/tb_pic_irq_core.sv
// ---------------------------------------------------------------------------
// tb_pic_irq_core
//
// Directed bench for pic_irq_core. An 8-channel instance covers nesting,
// EOI commands, AEOI rotation, spurious acks, level mode and init abort; a
// 16-channel instance covers vector wrap-around. Expected vectors are queued
// when the acknowledge is issued and popped by a monitor on vector_valid.
// ---------------------------------------------------------------------------
module tb_pic_irq_core;

  typedef enum {S_CFG, S_MASK, S_EOI, S_INTA} stimKind_e;

  logic clock;
  logic reset;

  // 8-channel instance
  logic [7:0] irqIn8;
  logic       cfgWrite8, cfgLevel8, cfgAeoi8, cfgRotate8;
  logic [7:0] cfgBase8;
  logic       maskWrite8;
  logic [7:0] maskData8;
  logic       eoiValid8;
  logic [1:0] eoiCmd8;
  logic [2:0] eoiLevel8;
  logic       inta8;
  logic       intOut8, vecValid8;
  logic [7:0] vecOut8, irr8, isr8, imr8;

  // 16-channel instance
  logic [15:0] irqIn16;
  logic        cfgWrite16, cfgLevel16, cfgAeoi16, cfgRotate16;
  logic [7:0]  cfgBase16;
  logic        maskWrite16;
  logic [15:0] maskData16;
  logic        eoiValid16;
  logic [1:0]  eoiCmd16;
  logic [3:0]  eoiLevel16;
  logic        inta16;
  logic        intOut16, vecValid16;
  logic [7:0]  vecOut16;
  logic [15:0] irr16, isr16, imr16;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] exp8[$];
  logic [7:0] exp16[$];

  pic_irq_core #(.NUM_IRQ(8), .VEC_WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .irq_in(irqIn8),
    .cfg_write(cfgWrite8), .cfg_level(cfgLevel8), .cfg_aeoi(cfgAeoi8),
    .cfg_auto_rotate(cfgRotate8), .cfg_vector_base(cfgBase8),
    .mask_write(maskWrite8), .mask_data(maskData8),
    .eoi_valid(eoiValid8), .eoi_cmd(eoiCmd8), .eoi_level(eoiLevel8),
    .inta_strobe(inta8), .int_out(intOut8), .vector_valid(vecValid8),
    .vector_out(vecOut8), .irr_out(irr8), .isr_out(isr8), .imr_out(imr8)
  );

  pic_irq_core #(.NUM_IRQ(16), .VEC_WIDTH(8)) dut16 (
    .clock(clock), .reset(reset), .irq_in(irqIn16),
    .cfg_write(cfgWrite16), .cfg_level(cfgLevel16), .cfg_aeoi(cfgAeoi16),
    .cfg_auto_rotate(cfgRotate16), .cfg_vector_base(cfgBase16),
    .mask_write(maskWrite16), .mask_data(maskData16),
    .eoi_valid(eoiValid16), .eoi_cmd(eoiCmd16), .eoi_level(eoiLevel16),
    .inta_strobe(inta16), .int_out(intOut16), .vector_valid(vecValid16),
    .vector_out(vecOut16), .irr_out(irr16), .isr_out(isr16), .imr_out(imr16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one value and log a failure line when it differs.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance n clock edges; returns 1 time unit after the last rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Issue one single-cycle strobe on the 8-channel instance.
  task automatic applyStimulus(input stimKind_e kind, input logic [31:0] a,
                               input logic [31:0] b);
    case (kind)
      S_CFG: begin
        cfgLevel8  = a[0];
        cfgAeoi8   = a[1];
        cfgRotate8 = a[2];
        cfgBase8   = b[7:0];
        cfgWrite8  = 1'b1;
      end
      S_MASK: begin
        maskData8  = a[7:0];
        maskWrite8 = 1'b1;
      end
      S_EOI: begin
        eoiCmd8   = a[1:0];
        eoiLevel8 = b[2:0];
        eoiValid8 = 1'b1;
      end
      default: inta8 = 1'b1;
    endcase
    tick(1);
    cfgWrite8  = 1'b0;
    maskWrite8 = 1'b0;
    eoiValid8  = 1'b0;
    inta8      = 1'b0;
  endtask

  // Full two-strobe acknowledge on the 8-channel instance, then the ACK2 cycle.
  task automatic doAck(input logic [7:0] expVec);
    applyStimulus(S_INTA, 0, 0);
    checkOutput("vvAfterStrobe1", {31'd0, vecValid8}, 32'd0);
    checkOutput("intDuringAck", {31'd0, intOut8}, 32'd0);
    exp8.push_back(expVec);
    applyStimulus(S_INTA, 0, 0);
    tick(1);
  endtask

  // Scoreboard monitors: every vector_valid pulse must match a queued vector.
  always @(negedge clock) begin
    if (vecValid8) begin
      if (exp8.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL vector8: got 0x%0h, expected no vector", vecOut8);
      end else begin
        checkOutput("vector8", {24'd0, vecOut8}, {24'd0, exp8.pop_front()});
      end
    end
    if (vecValid16) begin
      if (exp16.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL vector16: got 0x%0h, expected no vector", vecOut16);
      end else begin
        checkOutput("vector16", {24'd0, vecOut16}, {24'd0, exp16.pop_front()});
      end
    end
  end

  initial begin
    reset = 1'b1;
    irqIn8 = '0; cfgWrite8 = 0; cfgLevel8 = 0; cfgAeoi8 = 0; cfgRotate8 = 0;
    cfgBase8 = '0; maskWrite8 = 0; maskData8 = '0; eoiValid8 = 0;
    eoiCmd8 = '0; eoiLevel8 = '0; inta8 = 0;
    irqIn16 = '0; cfgWrite16 = 0; cfgLevel16 = 0; cfgAeoi16 = 0; cfgRotate16 = 0;
    cfgBase16 = '0; maskWrite16 = 0; maskData16 = '0; eoiValid16 = 0;
    eoiCmd16 = '0; eoiLevel16 = '0; inta16 = 0;
    tick(2);
    reset = 1'b0;
    tick(1);

    // Reset state
    checkOutput("resetImr", {24'd0, imr8}, 32'hFF);
    checkOutput("resetIrr", {24'd0, irr8}, 32'h00);
    checkOutput("resetIsr", {24'd0, isr8}, 32'h00);
    checkOutput("resetInt", {31'd0, intOut8}, 32'd0);
    checkOutput("resetVec", {24'd0, vecOut8}, 32'h00);

    // 1: edge mode, base 0x40, single request on channel 3
    applyStimulus(S_CFG, 0, 32'h40);
    applyStimulus(S_MASK, 0, 0);
    checkOutput("t1Imr", {24'd0, imr8}, 32'h00);
    irqIn8 = 8'h08;
    tick(1);
    checkOutput("t1Irr", {24'd0, irr8}, 32'h08);
    checkOutput("t1IntEarly", {31'd0, intOut8}, 32'd0);
    tick(1);
    checkOutput("t1Int", {31'd0, intOut8}, 32'd1);
    irqIn8 = 8'h00;
    doAck(8'h43);
    checkOutput("t1Isr", {24'd0, isr8}, 32'h08);
    checkOutput("t1IrrAfter", {24'd0, irr8}, 32'h00);
    checkOutput("t1IntAfter", {31'd0, intOut8}, 32'd0);

    // 2: fully nested with ISR[3] in service
    irqIn8 = 8'h22;
    tick(2);
    checkOutput("t2Int", {31'd0, intOut8}, 32'd1);
    doAck(8'h41);
    checkOutput("t2Isr", {24'd0, isr8}, 32'h0A);
    checkOutput("t2Irr", {24'd0, irr8}, 32'h20);
    tick(1);
    checkOutput("t2IntBlocked", {31'd0, intOut8}, 32'd0);
    applyStimulus(S_EOI, 0, 0);
    checkOutput("t2IsrEoi1", {24'd0, isr8}, 32'h08);
    tick(1);
    checkOutput("t2IntStillBlocked", {31'd0, intOut8}, 32'd0);
    applyStimulus(S_EOI, 0, 0);
    tick(1);
    checkOutput("t2Int5", {31'd0, intOut8}, 32'd1);
    doAck(8'h45);
    checkOutput("t2Isr5", {24'd0, isr8}, 32'h20);
    applyStimulus(S_EOI, 1, 5);
    checkOutput("t2SpecEoi", {24'd0, isr8}, 32'h00);
    irqIn8 = 8'h00;

    // 3: AEOI with auto-rotate, requests 0 and 4
    applyStimulus(S_CFG, 6, 32'h40);
    applyStimulus(S_MASK, 0, 0);
    irqIn8 = 8'h11;
    tick(2);
    checkOutput("t3Int", {31'd0, intOut8}, 32'd1);
    doAck(8'h40);
    checkOutput("t3Isr1", {24'd0, isr8}, 32'h00);
    checkOutput("t3Irr1", {24'd0, irr8}, 32'h10);
    tick(1);
    checkOutput("t3Int4", {31'd0, intOut8}, 32'd1);
    doAck(8'h44);
    checkOutput("t3Isr2", {24'd0, isr8}, 32'h00);
    irqIn8 = 8'h00;
    tick(1);
    irqIn8 = 8'h21;
    tick(2);
    // rotate_base is now 4, so channel 5 outranks channel 0
    doAck(8'h45);
    tick(1);
    doAck(8'h40);
    checkOutput("t3Isr3", {24'd0, isr8}, 32'h00);
    checkOutput("t3Irr3", {24'd0, irr8}, 32'h00);
    irqIn8 = 8'h00;

    // 4: level mode, request drops before the first strobe -> spurious
    applyStimulus(S_CFG, 1, 32'h40);
    applyStimulus(S_MASK, 0, 0);
    irqIn8 = 8'h04;
    tick(2);
    checkOutput("t4Int", {31'd0, intOut8}, 32'd1);
    irqIn8 = 8'h00;
    tick(1);
    doAck(8'h47);
    checkOutput("t4Isr", {24'd0, isr8}, 32'h00);

    // 5: level mode masking, then init abort between strobes
    applyStimulus(S_MASK, 32'h04, 0);
    irqIn8 = 8'h04;
    tick(2);
    checkOutput("t5IntMasked", {31'd0, intOut8}, 32'd0);
    checkOutput("t5IrrMasked", {24'd0, irr8}, 32'h04);
    applyStimulus(S_MASK, 0, 0);
    tick(1);
    checkOutput("t5IntUnmasked", {31'd0, intOut8}, 32'd1);
    applyStimulus(S_INTA, 0, 0);
    checkOutput("t5IsrAck1", {24'd0, isr8}, 32'h04);
    checkOutput("t5IrrAck1", {24'd0, irr8}, 32'h00);
    applyStimulus(S_CFG, 1, 32'h40);
    checkOutput("t5ImrCfg", {24'd0, imr8}, 32'hFF);
    checkOutput("t5IsrCfg", {24'd0, isr8}, 32'h00);
    checkOutput("t5IntCfg", {31'd0, intOut8}, 32'd0);
    tick(2);
    checkOutput("t5IntAfterCfg", {31'd0, intOut8}, 32'd0);
    applyStimulus(S_MASK, 0, 0);
    tick(1);
    checkOutput("t5IntReady", {31'd0, intOut8}, 32'd1);
    doAck(8'h42);
    irqIn8 = 8'h00;

    // 6: 16 channels, base 0xF8, channel 12 wraps the vector to 0x04
    cfgBase16 = 8'hF8;
    cfgWrite16 = 1'b1;
    tick(1);
    cfgWrite16 = 1'b0;
    maskData16 = 16'h0000;
    maskWrite16 = 1'b1;
    tick(1);
    maskWrite16 = 1'b0;
    irqIn16 = 16'h1000;
    tick(2);
    checkOutput("t6Int", {31'd0, intOut16}, 32'd1);
    inta16 = 1'b1;
    tick(1);
    inta16 = 1'b0;
    checkOutput("t6IsrAck1", {16'd0, isr16}, 32'h1000);
    exp16.push_back(8'h04);
    inta16 = 1'b1;
    tick(1);
    inta16 = 1'b0;
    tick(1);
    checkOutput("t6Isr", {16'd0, isr16}, 32'h1000);
    checkOutput("t6Irr", {16'd0, irr16}, 32'h0000);

    tick(2);
    checkOutput("pendingVectors8", exp8.size(), 32'd0);
    checkOutput("pendingVectors16", exp16.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
